sysid_check_ctrl: RTL and testbench
===================================

// Module: sysid_check_ctrl
// PURPOSE
// - Avalon-MM read master that sequences reads of the system-ID slave (ID word, then timestamp word).
// - Compares both words against build-time expected values and reports pass/fail to boot/status logic.
// - Holds the firmware/gateware release until the image is confirmed matched; optional periodic recheck.
// PARAMETERS
// - ADDR_W       1                 avm_address width (word address)
// - ID_ADDR      0                 word address of the ID register
// - TS_ADDR      1                 word address of the timestamp register
// - EXPECTED_ID  32'h0000000A      required ID value
// - EXPECTED_TS  32'd1461311182    required timestamp value
// - TIMEOUT_CYC  255               max cycles from read assertion to readdatavalid; valid range 1..65535
// - MAX_RETRY    2                 timeout retries before fatal; valid range 0..15
// - RECHECK_CYC  0                 cycles between automatic rechecks after pass; 0 = disabled
// - AUTO_START   1                 1 = start one check on the first cycle after reset release
// PORTS
// - clock            in   1   system clock
// - reset_n          in   1   asynchronous active-low reset
// - start            in   1   pulse: begin a check; ignored while busy=1
// - avm_address      out  ADDR_W  read address
// - avm_read         out  1   read request
// - avm_waitrequest  in   1   slave stall; read/address held while high
// - avm_readdata     in   32  read data
// - avm_readdatavalid in  1   read data valid
// - busy             out  1   check in progress
// - done             out  1   one-cycle pulse when a check completes (pass or fail)
// - pass             out  1   sticky: last check matched both words
// - fail             out  1   sticky: last check mismatched or timed out
// - timeout_err      out  1   sticky: fail caused by exhausted retries
// - id_seen          out  32  captured ID word
// - ts_seen          out  32  captured timestamp word
// BEHAVIOUR
// - Reset: every output is 0; FSM=IDLE; retry count, timeout counter and recheck counter are 0.
// - FSM: IDLE -> RD_ID_REQ -> RD_ID_WAIT -> RD_TS_REQ -> RD_TS_WAIT -> CHECK -> DONE.
// - IDLE/DONE: accept start (or AUTO_START trigger, or recheck expiry); on accept, clear pass/fail/timeout_err and the retry count, then enter RD_ID_REQ.
// - *_REQ: avm_read=1 with avm_address=ID_ADDR or TS_ADDR; advance to *_WAIT on the first edge with waitrequest=0.
// - *_WAIT: avm_read=0; on readdatavalid, capture readdata into id_seen or ts_seen and advance.
// - readdatavalid outside *_WAIT is ignored and changes no state. Exactly one read is outstanding at a time.
// - Timeout: counter clears on entry to *_REQ and increments each cycle in *_REQ or *_WAIT.
//   - At count==TIMEOUT_CYC with no readdatavalid: if retries<MAX_RETRY, increment retries and go to RD_ID_REQ.
//   - Otherwise set fail=1 and timeout_err=1, then go to DONE.
//   - readdatavalid arriving in the same cycle as the limit wins: data is taken and there is no timeout.
// - CHECK: one cycle.
//   - pass=1 iff id_seen==EXPECTED_ID and ts_seen==EXPECTED_TS; otherwise fail=1.
//   - A mismatch is never retried. done pulses on the CHECK->DONE edge.
// - busy=1 in all states except IDLE and DONE.
// - Latency: zero-wait slave with readdatavalid one cycle after acceptance -> done pulses 6 cycles after start is sampled.
// - Recheck: when RECHECK_CYC!=0, in DONE with pass=1, count to RECHECK_CYC and then self-start.
//   - An external start restarts and clears this counter. No recheck after a fail.
// - Reset mid-check: asynchronous return to reset state; avm_read drops immediately.
//   - A read still in flight at the slave is discarded, because the FSM is not in *_WAIT after reset.
// - start coincident with recheck expiry: treated as a single start.
// TESTING
// - T1 Happy path: AUTO_START=1, zero-wait model returns 10 then 1461311182.
//   -> pass=1, fail=0, one done pulse at the 6-cycle latency, id_seen=10.
// - T2 ID mismatch: model returns ID 11.
//   -> fail=1, pass=0, timeout_err=0, no retry, exactly 2 reads issued.
// - T3 Waitrequest stall: waitrequest held high 5 cycles on the TS read.
//   -> address stays at TS_ADDR and read stays 1, one read accepted, then pass.
// - T4 Timeout/retry: TIMEOUT_CYC=8, MAX_RETRY=2, readdatavalid never asserted.
//   -> 3 ID reads issued, then fail=1, timeout_err=1, done pulse.
//   - Repeat with readdatavalid on the limit cycle -> no retry.
// - T5 Start while busy plus stray readdatavalid in RD_TS_REQ.
//   -> start ignored, stray data not captured, result still pass.
// - T6 Reset mid-RD_TS_WAIT, then RECHECK_CYC=20.
//   -> outputs 0 immediately, check reruns, second check starts 20 cycles after DONE.

Source files
------------

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master that fetches the system-ID and timestamp words, compares them
// against build-time constants and reports pass/fail; optional periodic recheck after a pass.
module sysid_check_ctrl #(
   parameter int          ADDR_W      = 1,
   parameter int          ID_ADDR     = 0,
   parameter int          TS_ADDR     = 1,
   parameter logic [31:0] EXPECTED_ID = 32'h0000000A,
   parameter logic [31:0] EXPECTED_TS = 32'd1461311182,
   parameter int          TIMEOUT_CYC = 255,
   parameter int          MAX_RETRY   = 2,
   parameter int          RECHECK_CYC = 0,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout_err,
   output logic [31:0]       id_seen,
   output logic [31:0]       ts_seen
);

   localparam int                RC_W        = (RECHECK_CYC > 1) ? $clog2(RECHECK_CYC) : 1;
   localparam logic [RC_W-1:0]   RC_LAST     = RC_W'((RECHECK_CYC > 0) ? RECHECK_CYC - 1 : 0);
   localparam logic [15:0]       TO_LIMIT    = 16'(TIMEOUT_CYC);
   localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRY);
   localparam logic [ADDR_W-1:0] ID_A        = ADDR_W'(ID_ADDR);
   localparam logic [ADDR_W-1:0] TS_A        = ADDR_W'(TS_ADDR);

   typedef enum logic [2:0] {
      IDLE,
      RD_ID_REQ,
      RD_ID_WAIT,
      RD_TS_REQ,
      RD_TS_WAIT,
      CHECK,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            auto_pending;
   logic [15:0]     tmo_cnt;
   logic [3:0]      retry_cnt;
   logic [RC_W-1:0] recheck_cnt;

   logic accept;
   logic tmo;
   logic retry;
   logic tmo_fatal;
   logic cap_id;
   logic cap_ts;
   logic at_limit;
   logic recheck_fire;
   logic trigger;
   logic match;
   logic in_read;
   logic enter_req;

   assign at_limit     = (tmo_cnt == TO_LIMIT);
   assign recheck_fire = (RECHECK_CYC != 0) && (state == DONE) && pass && (recheck_cnt == RC_LAST);
   assign trigger      = start || auto_pending || recheck_fire;
   assign match        = (id_seen == EXPECTED_ID) && (ts_seen == EXPECTED_TS);
   assign in_read      = (state == RD_ID_REQ) || (state == RD_ID_WAIT) ||
                         (state == RD_TS_REQ) || (state == RD_TS_WAIT);

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      tmo        = 1'b0;
      retry      = 1'b0;
      tmo_fatal  = 1'b0;
      cap_id     = 1'b0;
      cap_ts     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (trigger) begin
               accept     = 1'b1;
               state_next = RD_ID_REQ;
            end
         end
         RD_ID_REQ: begin
            if (at_limit)              tmo = 1'b1;
            else if (!avm_waitrequest) state_next = RD_ID_WAIT;
         end
         RD_ID_WAIT: begin
            // data on the limit cycle still counts as a good read
            if (avm_readdatavalid) begin
               cap_id     = 1'b1;
               state_next = RD_TS_REQ;
            end else if (at_limit) begin
               tmo = 1'b1;
            end
         end
         RD_TS_REQ: begin
            if (at_limit)              tmo = 1'b1;
            else if (!avm_waitrequest) state_next = RD_TS_WAIT;
         end
         RD_TS_WAIT: begin
            if (avm_readdatavalid) begin
               cap_ts     = 1'b1;
               state_next = CHECK;
            end else if (at_limit) begin
               tmo = 1'b1;
            end
         end
         CHECK:   state_next = DONE;
         default: state_next = IDLE;
      endcase
      if (tmo) begin
         if (retry_cnt < RETRY_LIMIT) begin
            retry      = 1'b1;
            state_next = RD_ID_REQ;
         end else begin
            tmo_fatal  = 1'b1;
            state_next = DONE;
         end
      end
   end

   // a retry re-enters RD_ID_REQ, which must also restart the timeout window
   assign enter_req = ((state_next == RD_ID_REQ) || (state_next == RD_TS_REQ)) &&
                      ((state_next != state) || retry);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         auto_pending <= AUTO_START;
         tmo_cnt      <= '0;
         retry_cnt    <= '0;
         recheck_cnt  <= '0;
         avm_address  <= '0;
         avm_read     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail         <= 1'b0;
         timeout_err  <= 1'b0;
         id_seen      <= '0;
         ts_seen      <= '0;
      end else begin
         state        <= state_next;
         auto_pending <= 1'b0;
         done         <= (state_next == DONE) && (state != DONE);
         busy         <= (state_next != IDLE) && (state_next != DONE);
         avm_read     <= (state_next == RD_ID_REQ) || (state_next == RD_TS_REQ);
         avm_address  <= (state_next == RD_TS_REQ) ? TS_A : ID_A;

         if (enter_req)    tmo_cnt <= '0;
         else if (in_read) tmo_cnt <= tmo_cnt + 16'd1;

         if (accept)     retry_cnt <= '0;
         else if (retry) retry_cnt <= retry_cnt + 4'd1;

         if (accept)
            recheck_cnt <= '0;
         else if ((RECHECK_CYC != 0) && (state == DONE) && pass)
            recheck_cnt <= recheck_cnt + RC_W'(1);

         if (accept) begin
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout_err <= 1'b0;
         end else if (state == CHECK) begin
            pass <= match;
            fail <= !match;
         end else if (tmo_fatal) begin
            fail        <= 1'b1;
            timeout_err <= 1'b1;
         end

         if (cap_id) id_seen <= avm_readdata;
         if (cap_ts) ts_seen <= avm_readdata;
      end
   end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Randomized bench for sysid_check_ctrl: a behavioural Avalon slave plus a per-check
// outcome model derived from what the slave was told to return.
module tb_sysid_check_ctrl;

   localparam int          TO       = 8;
   localparam int          MR       = 2;
   localparam int          RC       = 20;
   localparam logic [31:0] EXP_ID   = 32'h0000000A;
   localparam logic [31:0] EXP_TS   = 32'd1461311182;
   localparam int          M_START  = 0;
   localparam int          M_RECHK  = 1;
   localparam int          M_AUTO   = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [0:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = '0;
   logic        avm_readdatavalid = 1'b0;
   logic        busy, done, pass, fail, timeout_err;
   logic [31:0] id_seen, ts_seen;

   sysid_check_ctrl #(
      .TIMEOUT_CYC (TO),
      .MAX_RETRY   (MR),
      .RECHECK_CYC (RC),
      .AUTO_START  (1'b1)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .busy              (busy),
      .done              (done),
      .pass              (pass),
      .fail              (fail),
      .timeout_err       (timeout_err),
      .id_seen           (id_seen),
      .ts_seen           (ts_seen)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // slave knobs for the next check
   logic [31:0] k_id, k_ts;
   int k_stall_id, k_stall_ts, k_delay, k_drops;
   bit k_stray, k_busy_start;

   // slave observations
   int id_reads, ts_reads, bus_viol, drops_left;

   // model expectations
   bit e_pass, e_timeout;
   int e_ids, e_tss;

   int  since_done = 0;
   bit  last_pass = 1'b0;
   int  txn = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_knobs(input logic [31:0] idv, input logic [31:0] tsv, input int sid,
                            input int sts, input int dly, input int drops, input bit stray,
                            input bit bstart);
      k_id = idv; k_ts = tsv; k_stall_id = sid; k_stall_ts = sts; k_delay = dly;
      k_drops = drops; k_stray = stray; k_busy_start = bstart;
      id_reads = 0; ts_reads = 0; bus_viol = 0; drops_left = drops;
   endtask

   // Whole-check outcome from the slave behaviour: a read times out if it is dropped or if
   // stall + response delay exceeds the window; MR+1 ID attempts are allowed in total.
   task automatic predict();
      int attempts;
      attempts = MR + 1;
      e_pass = 1'b0;
      if ((k_stall_id + k_delay > TO) || (k_drops >= attempts)) begin
         e_timeout = 1'b1; e_ids = attempts; e_tss = 0;
      end else begin
         e_timeout = 1'b0; e_ids = k_drops + 1; e_tss = 1;
         e_pass = (k_id == EXP_ID) && (k_ts == EXP_TS);
      end
   endtask

   // Behavioural Avalon slave; inputs change on the falling edge.
   initial begin : slave
      int          stall_left;
      int          resp_cnt;
      bit          in_req;
      bit          stray_pending;
      logic        req_addr;
      logic [31:0] resp_data;
      stall_left = 0; resp_cnt = 0; in_req = 0; stray_pending = 0; req_addr = 0; resp_data = 0;
      forever begin
         @(negedge clock);
         avm_readdatavalid = 1'b0;
         avm_readdata      = $urandom;
         if (!reset_n) begin
            in_req = 0; resp_cnt = 0; stray_pending = 0; avm_waitrequest = 1'b0;
         end else begin
            if (resp_cnt > 0) begin
               resp_cnt--;
               if (resp_cnt == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata      = resp_data;
               end
            end
            if (in_req && (!avm_read || avm_address[0] != req_addr)) begin
               bus_viol++;
               in_req = 0;
            end
            if (avm_read && !in_req) begin
               in_req        = 1;
               req_addr      = avm_address[0];
               stall_left    = req_addr ? k_stall_ts : k_stall_id;
               stray_pending = req_addr && k_stray;
            end
            if (in_req) begin
               if (stall_left > 0) begin
                  avm_waitrequest = 1'b1;
                  stall_left--;
                  if (stray_pending && !avm_readdatavalid) begin
                     avm_readdatavalid = 1'b1;
                     avm_readdata      = ~k_ts;
                     stray_pending     = 0;
                  end
               end else begin
                  avm_waitrequest = 1'b0;
                  in_req = 0;
                  if (req_addr) ts_reads++; else id_reads++;
                  if (!req_addr && drops_left > 0) begin
                     drops_left--;
                  end else begin
                     resp_cnt  = k_delay;
                     resp_data = req_addr ? k_ts : k_id;
                  end
               end
            end else begin
               avm_waitrequest = 1'b0;
            end
         end
      end
   end

   task automatic run_check(input int mode);
      int n;
      int gap;
      bit lat_case;
      predict();
      lat_case = (k_stall_id == 0) && (k_stall_ts == 0) && (k_delay == 1) && (k_drops == 0);
      if (mode == M_RECHK) begin
         gap = since_done;
         while (!avm_read && gap < 60) begin
            @(negedge clock);
            gap++;
         end
         check_eq("recheck_gap", gap, RC);
      end else if (mode == M_START) begin
         repeat ($urandom_range(1, 8)) @(negedge clock);
         start = 1'b1;
      end
      n = 0;
      while (!done && n < 400) begin
         @(negedge clock);
         n++;
         if (n == 1) start = 1'b0;
         if (n == 2) check_eq("busy_mid", busy, 1);
         if (k_busy_start && n == 3) start = 1'b1;
         if (k_busy_start && n == 4) start = 1'b0;
      end
      start = 1'b0;
      if (!done) begin
         check_eq("done_timeout", 0, 1);
         return;
      end
      if (mode != M_RECHK && lat_case) check_eq("latency", n, 6);
      check_eq("pass", pass, e_pass);
      check_eq("fail", fail, !e_pass);
      check_eq("timeout_err", timeout_err, e_timeout);
      check_eq("id_reads", id_reads, e_ids);
      check_eq("ts_reads", ts_reads, e_tss);
      check_eq("bus_hold", bus_viol, 0);
      check_eq("busy_done", busy, 0);
      if (!e_timeout) begin
         check_eq("id_seen", id_seen, k_id);
         check_eq("ts_seen", ts_seen, k_ts);
      end
      txn++;
      $display("check %0d mode=%0d id=%h ts=%h stall=%0d/%0d dly=%0d drops=%0d -> pass=%b fail=%b terr=%b lat=%0d",
               txn, mode, k_id, k_ts, k_stall_id, k_stall_ts, k_delay, k_drops,
               pass, fail, timeout_err, n);
      last_pass = pass;
      @(negedge clock);
      check_eq("done_width", done, 0);
      since_done = 1;
   endtask

   initial begin : main
      int  g;
      bit  saw;
      set_knobs(EXP_ID, EXP_TS, 0, 0, 1, 0, 0, 0);
      repeat (3) @(negedge clock);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_pass", pass, 0);
      check_eq("rst_fail", fail, 0);
      check_eq("rst_terr", timeout_err, 0);
      check_eq("rst_read", avm_read, 0);
      check_eq("rst_addr", avm_address, 0);
      check_eq("rst_id", id_seen, 0);
      check_eq("rst_ts", ts_seen, 0);

      // happy path via auto-start
      reset_n = 1'b1;
      run_check(M_AUTO);

      // ID mismatch: no retry, and no recheck afterwards
      set_knobs(32'd11, EXP_TS, 0, 0, 1, 0, 0, 0);
      run_check(M_START);
      saw = 0;
      repeat (30) begin
         @(negedge clock);
         saw = saw | avm_read;
      end
      check_eq("no_recheck", saw, 0);

      // never answered: retries exhausted
      set_knobs(EXP_ID, EXP_TS, 0, 0, 1, 3, 0, 0);
      run_check(M_START);
      // data exactly on the limit cycle is accepted
      set_knobs(EXP_ID, EXP_TS, 0, 0, TO, 0, 0, 0);
      run_check(M_START);
      // one cycle past the limit times out every attempt
      set_knobs(EXP_ID, EXP_TS, 0, 0, TO + 1, 0, 0, 0);
      run_check(M_START);

      // waitrequest stall on TS
      set_knobs(EXP_ID, EXP_TS, 0, 5, 1, 0, 0, 0);
      run_check(M_START);
      // stray data during TS stall plus start while busy, triggered by recheck
      set_knobs(EXP_ID, EXP_TS, 0, 3, 1, 0, 1, 1);
      run_check(M_RECHK);

      for (int i = 0; i < 30; i++) begin
         int sid, sts, drops, mode;
         logic [31:0] idv, tsv;
         idv   = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
         tsv   = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
         sid   = $urandom_range(0, 1) ? 0 : $urandom_range(1, 5);
         sts   = $urandom_range(0, 1) ? 0 : $urandom_range(1, 5);
         drops = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
         set_knobs(idv, tsv, sid, sts, $urandom_range(1, 3), drops,
                   (sts > 0) && $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         mode = (last_pass && $urandom_range(0, 1) == 1) ? M_RECHK : M_START;
         run_check(mode);
      end

      // reset while waiting for the TS word
      set_knobs(EXP_ID, EXP_TS, 0, 0, 4, 0, 0, 0);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      g = 0;
      while (!(avm_read && avm_address == 1'b1) && g < 100) begin
         @(negedge clock);
         g++;
      end
      check_eq("ts_req_seen", avm_read, 1);
      @(negedge clock);
      check_eq("busy_before_rst", busy, 1);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_read", avm_read, 0);
      check_eq("mid_rst_pass", pass, 0);
      check_eq("mid_rst_fail", fail, 0);
      check_eq("mid_rst_id", id_seen, 0);
      check_eq("mid_rst_ts", ts_seen, 0);
      repeat (2) @(negedge clock);
      set_knobs(EXP_ID, EXP_TS, 0, 0, 1, 0, 0, 0);
      reset_n = 1'b1;
      run_check(M_AUTO);
      set_knobs(EXP_ID, EXP_TS, 0, 0, 1, 0, 0, 0);
      run_check(M_RECHK);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
